piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out word serializer with a one-word
// holding register, so that back-to-back words stream without gaps.
//
// Parameters
//   WIDTH       word length in bits (2..32)
//   MSB_FIRST   1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
// Ports
//   Clk          clock, all state changes on its rising edge
//   Rst_n        asynchronous active-low reset
//   Load_valid   a parallel word is offered on D
//   D            parallel word
//   Load_ready   a word can be accepted this cycle (decoded from hold_full)
//   Q            serial data bit
//   Q_valid      Q carries a valid bit
//   Frame_start  Q carries the first bit of a word
//   Last         Q carries the last bit of a word
module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Load_valid,
    input  logic [WIDTH-1:0] D,
    output logic             Load_ready,
    output logic             Q,
    output logic             Q_valid,
    output logic             Frame_start,
    output logic             Last
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic             q_out_q, q_out_d;
    logic             q_valid_q, q_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             last_q, last_d;

    logic             accept;
    logic [WIDTH-1:0] shift_adv;

    // Ready depends only on registered state, never on Load_valid.
    assign Load_ready  = ~hold_full_q;
    assign Q           = q_out_q;
    assign Q_valid     = q_valid_q;
    assign Frame_start = frame_start_q;
    assign Last        = last_q;

    // Next-state logic: shifter, counter, holding register and FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        accept      = Load_valid & ~hold_full_q;

        // The bit to emit always sits at the output end of the shifter.
        if (MSB_FIRST) begin
            shift_adv = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
            shift_adv = {1'b0, shift_q[WIDTH-1:1]};
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = D;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    shift_d = shift_adv;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (accept) begin
                        hold_d      = D;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // Buffered word follows immediately; ready was low, so no accept.
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (accept) begin
                    shift_d = D;
                    cnt_d   = '0;
                end else begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from next-state values so they line up
        // with the state they describe, one cycle after the accepting edge.
        q_valid_d     = (state_d == SHIFT);
        frame_start_d = q_valid_d && (cnt_d == '0);
        last_d        = q_valid_d && (cnt_d == CNT_LAST);
        q_out_d       = q_valid_d && (MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0]);
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            q_out_q       <= 1'b0;
            q_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            q_out_q       <= q_out_d;
            q_valid_q     <= q_valid_d;
            frame_start_q <= frame_start_d;
            last_q        <= last_d;
        end
    end

endmodule
